// File: rtl/divider_nb.sv
// rtl/divider_nb.sv - nb-bit restoring divider, one quotient bit per cycle.
// Signed operation is enabled by defining DIVIDER_NB_SIGNED_EN; unsigned otherwise.
module divider_nb #(
  parameter int nb = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [nb-1:0] A,
  input  logic [nb-1:0] B,
  output logic [nb-1:0] Quotient,
  output logic [nb-1:0] Remainder,
  output logic          div_by_zero,
  output logic          ready
);

`ifdef DIVIDER_NB_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  localparam int CW = $clog2(nb + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [nb-1:0] r_dvd;
  logic [nb-1:0] r_dvs;
  logic [nb-1:0] r_rem;
  logic [nb-1:0] r_a;
  logic          r_neg_a;
  logic          r_neg_q;
  logic          r_bz;

  logic          w_sa;
  logic          w_sb;
  logic [nb-1:0] w_mag_a;
  logic [nb-1:0] w_mag_b;
  logic [nb:0]   w_rsh;
  logic          w_ge;
  logic [nb-1:0] w_diff;

  assign w_sa    = SIGNED_EN & A[nb-1];
  assign w_sb    = SIGNED_EN & B[nb-1];
  assign w_mag_a = w_sa ? (~A + 1'b1) : A;
  assign w_mag_b = w_sb ? (~B + 1'b1) : B;

  // Partial remainder is nb+1 bits: previous remainder shifted left plus next dividend bit.
  assign w_rsh  = {r_rem, r_dvd[nb-1]};
  assign w_ge   = (w_rsh >= {1'b0, r_dvs});
  assign w_diff = w_rsh[nb-1:0] - r_dvs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_a         <= '0;
      r_neg_a     <= 1'b0;
      r_neg_q     <= 1'b0;
      r_bz        <= 1'b0;
      Quotient    <= '0;
      Remainder   <= '0;
      div_by_zero <= 1'b0;
      ready       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_dvd   <= w_mag_a;
            r_dvs   <= w_mag_b;
            r_rem   <= '0;
            r_a     <= A;
            r_neg_a <= w_sa;
            r_neg_q <= w_sa ^ w_sb;
            r_bz    <= (B == '0);
            r_cnt   <= CW'(nb);
            ready   <= 1'b0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_rem <= w_ge ? w_diff : w_rsh[nb-1:0];
          r_dvd <= {r_dvd[nb-2:0], w_ge};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= FIX;
        end
        FIX: begin
          // Magnitude of the most negative value negates to itself, giving the wrapped overflow quotient.
          if (r_bz) begin
            Quotient  <= '1;
            Remainder <= r_a;
          end else begin
            Quotient  <= r_neg_q ? (~r_dvd + 1'b1) : r_dvd;
            Remainder <= r_neg_a ? (~r_rem + 1'b1) : r_rem;
          end
          div_by_zero <= r_bz;
          ready       <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_nb.sv
// tb/tb_divider_nb.sv - directed and random checks of divider_nb at nb=8.
module tb_divider_nb;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] Quotient;
  logic [7:0] Remainder;
  logic       div_by_zero;
  logic       ready;

  int n_vec;
  int n_err;

  divider_nb #(.nb(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .A           (A),
    .B           (B),
    .Quotient    (Quotient),
    .Remainder   (Remainder),
    .div_by_zero (div_by_zero),
    .ready       (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulses start for one edge, then counts edges until ready (bounded).
  task automatic run_div(input logic [7:0] a, input logic [7:0] b, output int lat);
    @(negedge clk);
    start = 1'b1;
    A = a;
    B = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = 8'h00;
    B = 8'h00;
    lat = 0;
    while (!ready && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic div_chk(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] q, input logic [7:0] r, input logic dz);
    int lat;
    run_div(a, b, lat);
    chk({tag, "_lat"}, lat, 9);
    chk({tag, "_q"}, Quotient, q);
    chk({tag, "_r"}, Remainder, r);
    chk({tag, "_dz"}, div_by_zero, dz);
  endtask

  initial begin
    int lat;
    logic [7:0] ra, rb, eq, er;
    n_vec = 0;
    n_err = 0;
    start = 1'b0;
    A = 8'h00;
    B = 8'h00;
    rst_n = 1'b0;
    #23;
    chk("rst_q", Quotient, 8'h00);
    chk("rst_r", Remainder, 8'h00);
    chk("rst_dz", div_by_zero, 1'b0);
    chk("rst_rdy", ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    div_chk("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
    div_chk("dff_10", 8'hFF, 8'h10,
`ifdef DIVIDER_NB_SIGNED_EN
            8'h00, 8'hFF, 1'b0);
`else
            8'h0F, 8'h0F, 1'b0);
`endif
    div_chk("d5_0", 8'd5, 8'd0, 8'hFF, 8'h05, 1'b1);
    div_chk("d9_4", 8'd9, 8'd4, 8'd2, 8'd1, 1'b0);
`ifdef DIVIDER_NB_SIGNED_EN
    div_chk("dm100_7", 8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0);
    div_chk("dm128_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0);
    div_chk("d100_m7", 8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0);
    div_chk("dm5_0", 8'hFB, 8'h00, 8'hFF, 8'hFB, 1'b1);
`else
    div_chk("d156_7", 8'h9C, 8'd7, 8'h16, 8'h02, 1'b0);
    div_chk("d128_255", 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0);
    div_chk("d255_1", 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0);
`endif

    // Restart attempt mid-RUN; also outputs must hold the previous result until FIX.
    div_chk("pre", 8'd50, 8'd5, 8'd10, 8'd0, 1'b0);
    @(negedge clk);
    start = 1'b1;
    A = 8'd100;
    B = 8'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_rdy_clr", ready, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    A = 8'd1;
    B = 8'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("hold_q", Quotient, 8'd10);
    lat = 3;
    while (!ready && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("rs_lat", lat, 9);
    chk("rs_q", Quotient, 8'd33);
    chk("rs_r", Remainder, 8'd1);

    // Asynchronous reset mid-RUN.
    @(negedge clk);
    start = 1'b1;
    A = 8'd77;
    B = 8'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_q", Quotient, 8'h00);
    chk("ar_r", Remainder, 8'h00);
    chk("ar_rdy", ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("ar_rdy_stay", ready, 1'b0);
    chk("ar_q_stay", Quotient, 8'h00);
    div_chk("ar_new", 8'd77, 8'd3, 8'd25, 8'd2, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (i % 50 == 0) rb = 8'h00;
      if (rb == 8'h00) begin
        eq = 8'hFF;
        er = ra;
      end else begin
`ifdef DIVIDER_NB_SIGNED_EN
        if (ra == 8'h80 && rb == 8'hFF) begin
          eq = 8'h80;
          er = 8'h00;
        end else begin
          eq = 8'($signed(ra) / $signed(rb));
          er = 8'($signed(ra) % $signed(rb));
        end
`else
        eq = ra / rb;
        er = ra % rb;
`endif
      end
      run_div(ra, rb, lat);
      n_vec++;
      assert (lat == 9 && Quotient === eq && Remainder === er && div_by_zero === (rb == 8'h00)) else begin
        n_err++;
        $error("FAIL rnd %0h/%0h: observed q=%0h r=%0h dz=%0b lat=%0d expected q=%0h r=%0h dz=%0b lat=9",
               ra, rb, Quotient, Remainder, div_by_zero, lat, eq, er, (rb == 8'h00));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
